vdc_regbank: RTL and testbench

Parametrised CPU-side register bank for the VDC family, generalising the fixed 38-register file into a standalone block. Provides the indirect address/data port pair ($D600/$D601 style), per-register writable-bit masks, and the status register. Adds light-pen capture with input synchronisation and frame-synchronous shadowing of timing registers. Sits between the CPU bus and the vdc_signals, vdc_ramiface and vdc_video consumers, which read the flat register vector.

---
 rtl/vdc_regbank.sv | 145 ++++++++++++++
 tb/tb_vdc_regbank.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vdc_regbank.sv
// vdc_regbank: CPU-side register bank for the VDC family.
// Provides an indirect select/data port pair, per-register writable-bit masks,
// a status register, light-pen capture and frame-synchronous shadowing of the
// timing registers.
// Optional feature macro: VDC_REGBANK_AUTOINC_EN (data-port accesses advance
// the register select).
module vdc_regbank #(
  parameter int                      NUM_REGS  = 38,
  parameter int                      SEL_BITS  = 6,
  parameter logic [8*NUM_REGS-1:0]   WMASK     = {NUM_REGS{8'hFF}},
  parameter int                      SHADOW_LO = 0,
  parameter int                      SHADOW_HI = 9,
  parameter int                      LPV_IDX   = 16,
  parameter int                      LPH_IDX   = 17
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enableBus,
  input  logic                       cs,
  input  logic                       rs,
  input  logic                       we,
  input  logic [7:0]                 db_in,
  output logic [7:0]                 db_out,
  input  logic                       version,
  input  logic                       busy,
  input  logic                       vVisible,
  input  logic                       frame_start,
  input  logic                       lp_n,
  input  logic [7:0]                 col,
  input  logic [7:0]                 row,
  output logic [8*NUM_REGS-1:0]      regs,
  output logic                       wr_strobe,
  output logic [SEL_BITS-1:0]        wr_idx
);

  // Which registers live behind a pending copy; built once at elaboration.
  function automatic logic [NUM_REGS-1:0] shadow_map();
    logic [NUM_REGS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (i >= SHADOW_LO && i <= SHADOW_HI) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [NUM_REGS-1:0]      SHMASK  = shadow_map();
  localparam logic [NUM_REGS-1:0][7:0] WM      = WMASK;
  localparam logic [SEL_BITS:0]        NREG_W  = (SEL_BITS+1)'(NUM_REGS);
  localparam logic [SEL_BITS-1:0]      LPV_SEL = SEL_BITS'(LPV_IDX);
  localparam logic [SEL_BITS-1:0]      LPH_SEL = SEL_BITS'(LPH_IDX);
  localparam logic [SEL_BITS-1:0]      LAST    = SEL_BITS'(NUM_REGS - 1);

  logic [SEL_BITS-1:0]      regSel_q, regSel_d;
  logic [NUM_REGS-1:0][7:0] live_q, pend_q;
  logic [7:0]               db_out_q, rd_data;
  logic                     lpStatus_q, lpStatus_d;
  logic                     lp_s1_q, lp_s2_q, lp_s3_q;
  logic                     wr_strobe_q;
  logic [SEL_BITS-1:0]      wr_idx_q;

  logic sel_in, sel_ro, sel_sh, sel_wr, dat_acc, dat_wr, wr_acc, rd, lp_cap, lp_clr;
  logic [7:0] wsel, wdata;

  assign sel_in  = {1'b0, regSel_q} < NREG_W;
  assign sel_ro  = (regSel_q == LPV_SEL) || (regSel_q == LPH_SEL);
  assign sel_sh  = sel_in && SHMASK[regSel_q];
  assign wsel    = sel_in ? WM[regSel_q] : 8'h00;
  assign wdata   = db_in & wsel;
  assign sel_wr  = cs & we & enableBus & ~rs;
  assign dat_wr  = cs & we & enableBus & rs;
  assign rd      = cs & ~we;
  assign dat_acc = dat_wr | (rd & rs);
  assign wr_acc  = dat_wr & sel_in & ~sel_ro;
  // Capture looks at the flag as it stood before this cycle, so a clearing
  // read in the same cycle never hides a fresh capture.
  assign lp_cap  = lp_s2_q & ~lp_s3_q & ~lpStatus_q;
  assign lp_clr  = rd & rs & sel_ro;

  // Read mux: status port, or masked register value (unwritable bits read 1).
  always_comb begin
    rd_data = 8'hFF;
    if (!rs)
      rd_data = {~busy, lpStatus_q, ~vVisible, 3'b000, version, ~version};
    else if (sel_in)
      rd_data = (sel_sh ? pend_q[regSel_q] : live_q[regSel_q]) | ~wsel;
  end

  // Next register select: select-port write, optionally data-port advance.
  always_comb begin
    regSel_d = regSel_q;
    if (sel_wr) regSel_d = db_in[SEL_BITS-1:0];
`ifdef VDC_REGBANK_AUTOINC_EN
    else if (dat_acc) regSel_d = (regSel_q == LAST) ? '0 : regSel_q + 1'b1;
`endif
  end

  // Light-pen flag: set on capture, cleared by reading either light-pen register.
  always_comb begin
    lpStatus_d = lpStatus_q;
    if (lp_clr) lpStatus_d = 1'b0;
    if (lp_cap) lpStatus_d = 1'b1;
  end

  // Register file, pending copies, light-pen capture, port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regSel_q    <= '0;
      live_q      <= '0;
      pend_q      <= '0;
      db_out_q    <= 8'h00;
      lpStatus_q  <= 1'b0;
      lp_s1_q     <= 1'b1;
      lp_s2_q     <= 1'b1;
      lp_s3_q     <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
    end else begin
      regSel_q   <= regSel_d;
      lpStatus_q <= lpStatus_d;
      lp_s1_q    <= lp_n;
      lp_s2_q    <= lp_s1_q;
      lp_s3_q    <= lp_s2_q;
      if (rd) db_out_q <= rd_data;
      // Live copies take the pending value held before this edge.
      if (frame_start)
        for (int i = 0; i < NUM_REGS; i++)
          if (SHMASK[i]) live_q[i] <= pend_q[i];
      if (wr_acc) begin
        if (sel_sh) pend_q[regSel_q] <= wdata;
        else        live_q[regSel_q] <= wdata;
      end
      if (lp_cap) begin
        live_q[LPV_IDX] <= row;
        live_q[LPH_IDX] <= col;
      end
      wr_strobe_q <= wr_acc;
      if (wr_acc) wr_idx_q <= regSel_q;
    end
  end

  assign db_out    = db_out_q;
  assign regs      = live_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_idx    = wr_idx_q;

endmodule

// File: tb/tb_vdc_regbank.sv
// Bench for vdc_regbank: directed stimulus pushes expected read data and
// write strobes into queues; a monitor pops and compares on each DUT output.
module tb_vdc_regbank;
  localparam int NR = 38;
  localparam logic [8*NR-1:0] WMK = {{32{8'hFF}}, 8'h1F, {5{8'hFF}}};

  logic clk = 1'b0, reset_n = 1'b0;
  logic enableBus = 0, cs = 0, rs = 0, we = 0;
  logic [7:0] db_in = 0, col = 0, row = 0;
  logic version = 0, busy = 0, vVisible = 1, frame_start = 0, lp_n = 1;
  logic [7:0] db_out;
  logic [8*NR-1:0] regs;
  logic wr_strobe;
  logic [5:0] wr_idx;

  int checks = 0, failures = 0;
  logic [7:0] rd_q[$];
  logic [5:0] wr_q[$];
  bit rd_pend = 0;

  vdc_regbank #(.NUM_REGS(NR), .SEL_BITS(6), .WMASK(WMK)) dut (
    .clk(clk), .reset_n(reset_n), .enableBus(enableBus), .cs(cs), .rs(rs),
    .we(we), .db_in(db_in), .db_out(db_out), .version(version), .busy(busy),
    .vVisible(vVisible), .frame_start(frame_start), .lp_n(lp_n), .col(col),
    .row(row), .regs(regs), .wr_strobe(wr_strobe), .wr_idx(wr_idx));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic chkreg(input int i, input logic [7:0] exp);
    chk($sformatf("regs[%0d]", i), regs[8*i +: 8], exp);
  endtask

  // One bus cycle; inputs change 1 time unit after the active edge.
  task automatic bus(input logic rs_v, input logic we_v, input logic [7:0] d);
    cs = 1; we = we_v; rs = rs_v; enableBus = 1; db_in = d;
    @(posedge clk); #1;
    cs = 0; we = 0; rs = 0; enableBus = 0;
  endtask

  task automatic rdx(input logic rs_v, input logic [7:0] exp);
    rd_q.push_back(exp);
    bus(rs_v, 1'b0, 8'h00);
  endtask

  task automatic wrx(input logic [5:0] idx, input logic [7:0] d);
    wr_q.push_back(idx);
    bus(1'b1, 1'b1, d);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame();
    frame_start = 1; cyc(1); frame_start = 0;
  endtask

  task automatic lp_pulse();
    lp_n = 0; cyc(4); lp_n = 1; cyc(5);
  endtask

  // Reads complete one edge after issue.
  always @(posedge clk) rd_pend <= reset_n && cs && !we;

  // Monitor: compare DUT outputs against queued expectations.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL db_out: unexpected read data %02h", db_out);
      end else chk("db_out", db_out, rd_q.pop_front());
    end
    if (reset_n && wr_strobe) begin
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_strobe: unexpected strobe idx %0d", wr_idx);
      end else chk("wr_idx", {2'b00, wr_idx}, {2'b00, wr_q.pop_front()});
    end
  end

  initial begin
    cyc(2);
    reset_n = 1; cyc(1);
    // Reset asserted in the middle of a write to R1.
    bus(1'b0, 1'b1, 8'd1);
    cs = 1; we = 1; rs = 1; enableBus = 1; db_in = 8'h50;
    #2 reset_n = 0;
    @(posedge clk); #1;
    checks++;
    if (regs !== '0) begin failures++; $display("FAIL reset_regs: got nonzero expected zero"); end
    chk("reset_db_out", db_out, 8'h00);
    chk("reset_wr_strobe", {7'd0, wr_strobe}, 8'h00);
    cs = 0; we = 0; rs = 0; enableBus = 0;
    #3 reset_n = 1;
    cyc(1);
    chkreg(1, 8'h00);

    // Status port.
    rdx(1'b0, 8'h81);
    busy = 1; version = 1; vVisible = 0;
    rdx(1'b0, 8'h22);
    busy = 0; version = 0; vVisible = 1;

    // Writable-bit mask on R5 (shadowed) and out-of-range index.
    bus(1'b0, 1'b1, 8'd5); wrx(6'd5, 8'hFF);
    chkreg(5, 8'h00);
    frame();
    chkreg(5, 8'h1F);
    bus(1'b0, 1'b1, 8'd5); rdx(1'b1, 8'hFF);
    bus(1'b0, 1'b1, 8'd40); rdx(1'b1, 8'hFF);
    bus(1'b0, 1'b1, 8'd40); bus(1'b1, 1'b1, 8'hAA);

    // Frame shadowing of R0.
    bus(1'b0, 1'b1, 8'd0); wrx(6'd0, 8'h7E);
    bus(1'b0, 1'b1, 8'd0); rdx(1'b1, 8'h7E);
    chkreg(0, 8'h00);
    frame();
    chkreg(0, 8'h7E);
    bus(1'b0, 1'b1, 8'd0);
    frame_start = 1; wrx(6'd0, 8'h7F); frame_start = 0;
    chkreg(0, 8'h7E);
    bus(1'b0, 1'b1, 8'd0); rdx(1'b1, 8'h7F);
    chkreg(0, 8'h7E);
    frame();
    chkreg(0, 8'h7F);

    // Light pen capture, ignore while set, clear on read, recapture.
    col = 8'h22; row = 8'h0C;
    lp_pulse();
    rdx(1'b0, 8'hC1);
    chkreg(16, 8'h0C);
    chkreg(17, 8'h22);
    col = 8'h30; row = 8'h05;
    lp_pulse();
    chkreg(17, 8'h22);
    bus(1'b0, 1'b1, 8'd17); rdx(1'b1, 8'h22);
    rdx(1'b0, 8'h81);
    lp_pulse();
    chkreg(16, 8'h05);
    chkreg(17, 8'h30);
    rdx(1'b0, 8'hC1);
    bus(1'b0, 1'b1, 8'd16); bus(1'b1, 1'b1, 8'h55);
    chkreg(16, 8'h05);

    // Non-shadowed write.
    bus(1'b0, 1'b1, 8'd26); wrx(6'd26, 8'hF0);
    chkreg(26, 8'hF0);
`ifdef VDC_REGBANK_AUTOINC_EN
    bus(1'b0, 1'b1, 8'd34);
    wrx(6'd34, 8'h7D);
    wrx(6'd35, 8'h64);
    chkreg(34, 8'h7D);
    chkreg(35, 8'h64);
    bus(1'b0, 1'b1, 8'd37);
    rdx(1'b1, 8'h00);
    rdx(1'b1, 8'h7F);
`else
    wrx(6'd26, 8'h11);
    chkreg(26, 8'h11);
`endif

    cyc(3);
    chk("rd_q_empty", 8'(rd_q.size()), 8'h00);
    chk("wr_q_empty", 8'(wr_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
